iiitb_bm_scheduler: RTL and testbench

IIITB_BM_SCHEDULER -- requirements
Module: iiitb_bm_scheduler

---
 rtl/iiitb_bm_scheduler.sv | 118 +++++++++++
 tb/tb_iiitb_bm_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_bm_scheduler.sv
// Two-requester round-robin front end for a shared multi-cycle Booth multiplier.
// Grants one operand pair, pulses the multiplier load, waits LAT cycles, then holds the product until consumed.
module iiitb_bm_scheduler #(
    parameter int LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_m,
    input  logic [3:0] req0_q,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_m,
    input  logic [3:0] req1_q,
    output logic       req1_ready,
    output logic       mul_load,
    output logic [3:0] mul_m,
    output logic [3:0] mul_q,
    input  logic [7:0] mul_p,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    input  logic       rsp_ready,
    output logic [1:0] o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // reqN_ready is combinational and only ever high in IDLE; rsp_valid is high exactly in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAT3 = 3'(LAT);

    state_t     r_state;
    logic       r_ptr;
    logic [2:0] r_cnt;
    logic       r_id;
    logic       r_mul_load;
    logic [3:0] r_mul_m;
    logic [3:0] r_mul_q;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_p;

    logic       w_idle;
    logic       w_any;
    logic       w_grant1;

    assign w_idle   = (r_state == IDLE) && !reset;
    assign w_any    = req0_valid || req1_valid;
    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign w_grant1 = req1_valid && (!req0_valid || r_ptr);

    assign req0_ready  = w_idle && req0_valid && !w_grant1;
    assign req1_ready  = w_idle && w_grant1;

    assign mul_load    = r_mul_load;
    assign mul_m       = r_mul_m;
    assign mul_q       = r_mul_q;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_id;
    assign rsp_p       = r_rsp_p;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_cnt       <= 3'd0;
            r_id        <= 1'b0;
            r_mul_load  <= 1'b0;
            r_mul_m     <= 4'd0;
            r_mul_q     <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id       <= w_grant1;
                        r_mul_m    <= w_grant1 ? req1_m : req0_m;
                        r_mul_q    <= w_grant1 ? req1_q : req0_q;
                        r_mul_load <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_mul_load <= 1'b0;
                    r_cnt      <= LAT3;
                    r_state    <= RUN;
                end
                RUN: begin
                    // Counter reaching 1 marks the last RUN cycle: the product is valid now.
                    if (r_cnt == 3'd1) begin
                        r_cnt       <= 3'd0;
                        r_rsp_p     <= mul_p;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= ~r_id;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iiitb_bm_scheduler.sv
// Self-checking bench for iiitb_bm_scheduler: behavioural multiplier, round-robin reference model,
// expected-response queue and directed plus randomized scenarios.
module tb_iiitb_bm_scheduler;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic       req0_ready, req1_ready;
    logic       mul_load;
    logic [3:0] mul_m, mul_q;
    logic [7:0] mul_p;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_p;
    logic       rsp_ready = 1'b0;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iiitb_bm_scheduler #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_m(req0_m), .req0_q(req0_q), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_m(req1_m), .req1_q(req1_q), .req1_ready(req1_ready),
        .mul_load(mul_load), .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
        .o_dbg_state(dbg_state)
    );

    // External multiplier: product appears LAT cycles after the load edge, inverted garbage before that.
    logic [7:0] mdl_prod;
    int         mdl_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_cnt  <= -1;
            mdl_prod <= 8'd0;
        end else if (mul_load) begin
            mdl_prod <= 8'(int'($signed(mul_m)) * int'($signed(mul_q)));
            mdl_cnt  <= LAT - 1;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end
    assign mul_p = (mdl_cnt == 0) ? mdl_prod : ~mdl_prod;

    // Reference model: pointer, winner choice and expected {id, product} queue.
    int         tb_ptr = 0;
    logic [8:0] exp_q[$];

    function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
        int a, b;
        a = $signed(m);
        b = $signed(q);
        return 8'(a * b);
    endfunction

    task automatic model_issue(input logic v0, input logic v1, input logic [3:0] m0, input logic [3:0] q0,
                               input logic [3:0] m1, input logic [3:0] q1, output int w);
        if (v0 && v1) w = tb_ptr;
        else w = v1 ? 1 : 0;
        exp_q.push_back({w[0], (w == 1) ? ref_prod(m1, q1) : ref_prod(m0, q0)});
    endtask

    // Driver: offer a request in IDLE, follow it to DONE, hold off rsp_ready for 'hold' cycles, then consume.
    task automatic transact(input logic v0, input logic v1, input logic [3:0] m0, input logic [3:0] q0,
                            input logic [3:0] m1, input logic [3:0] q1, input int hold,
                            output logic rdy0, output logic rdy1, output int lat, output int loads,
                            output logic id, output logic [7:0] p, output bit tmo);
        tmo = 0; lat = 0; loads = 0; id = 0; p = 0;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_m = m0; req0_q = q0; req1_m = m1; req1_q = q1;
        rsp_ready = 1'b0;
        #1;
        rdy0 = req0_ready;
        rdy1 = req1_ready;
        if (!(rdy0 || rdy1)) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            tmo = 1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (mul_load) loads++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mul_load) loads++;
            if (rsp_valid) break;
            rsp_ready = 1'($urandom_range(0, 1));
        end
        rsp_ready = 1'b0;
        if (!rsp_valid) begin
            tmo = 1;
            return;
        end
        id = rsp_id;
        p  = rsp_p;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
        checks++; if ({mul_load, mul_m, mul_q, rsp_valid, rsp_id, rsp_p} !== 19'd0) begin errors++; $display("FAIL reset_outputs: got load=%b m=%h q=%h v=%b id=%b p=%h want all 0", mul_load, mul_m, mul_q, rsp_valid, rsp_id, rsp_p); end
        repeat (2) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        tb_ptr = 0;
        exp_q.delete();
    endtask

    task automatic test_single();
        logic r0, r1, id; logic [7:0] p; int lat, loads, w; bit tmo;
        model_issue(1, 0, 4'b1010, 4'b1011, 4'd0, 4'd0, w);
        transact(1, 0, 4'b1010, 4'b1011, 4'd0, 4'd0, 0, r0, r1, lat, loads, id, p, tmo);
        checks++; if (tmo !== 0) begin errors++; $display("FAIL single_timeout: got tmo=%0d want 0", tmo); end
        checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b want 10", r0, r1); end
        checks++; if (loads !== 1) begin errors++; $display("FAIL single_load_pulse: got %0d cycles want 1", loads); end
        // Counting the grant edge as the first edge, DONE is entered LAT+1 edges later.
        checks++; if (lat !== LAT + 1) begin errors++; $display("FAIL single_latency: got %0d edges want %0d", lat, LAT + 1); end
        checks++; if (p !== 8'b00011110 || id !== 1'b0) begin errors++; $display("FAIL single_result: got id=%b p=%h want id=0 p=1e", id, p); end
        void'(exp_q.pop_front());
        tb_ptr = 1;
    endtask

    task automatic test_contention();
        logic r0, r1, id; logic [7:0] p, m0, q0, m1, q1; logic [8:0] e; int lat, loads, w; bit tmo;
        for (int i = 0; i < 4; i++) begin
            m0 = 8'($urandom_range(0, 15)); q0 = 8'($urandom_range(0, 15));
            m1 = 8'($urandom_range(0, 15)); q1 = 8'($urandom_range(0, 15));
            if (i == 0) tb_ptr = 0;
            model_issue(1, 1, m0[3:0], q0[3:0], m1[3:0], q1[3:0], w);
            if (i == 0) begin
                @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
            end
            transact(1, 1, m0[3:0], q0[3:0], m1[3:0], q1[3:0], 0, r0, r1, lat, loads, id, p, tmo);
            e = exp_q.pop_front();
            checks++; if (tmo !== 0 || r0 !== (w == 0) || r1 !== (w == 1)) begin errors++; $display("FAIL contention_grant[%0d]: got rdy=%b%b tmo=%0d want winner %0d", i, r0, r1, tmo, w); end
            checks++; if (id !== 1'(i % 2)) begin errors++; $display("FAIL contention_alternation[%0d]: got id=%b want %0d", i, id, i % 2); end
            checks++; if ({id, p} !== e) begin errors++; $display("FAIL contention_result[%0d]: got %h want %h", i, {id, p}, e); end
            tb_ptr = e[8] ? 0 : 1;
        end
    endtask

    task automatic test_busy_blocking();
        logic [3:0] m0, q0, m1, q1; logic [8:0] e; int w; bit leak;
        m0 = 4'($urandom_range(0, 15)); q0 = 4'($urandom_range(0, 15));
        m1 = 4'($urandom_range(0, 15)); q1 = 4'($urandom_range(0, 15));
        model_issue(1, 0, m0, q0, 4'd0, 4'd0, w);
        @(negedge clk); req0_valid = 1'b1; req0_m = m0; req0_q = q0; #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL busy_first_grant: got %b want 1", req0_ready); end
        @(posedge clk); @(negedge clk); req0_valid = 1'b0;
        @(posedge clk); @(negedge clk); req1_valid = 1'b1; req1_m = m1; req1_q = q1;
        leak = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            #1; if (req1_ready) leak = 1;
            @(posedge clk); @(negedge clk);
        end
        #1; if (req1_ready) leak = 1;
        e = exp_q.pop_front();
        checks++; if (leak !== 0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL busy_blocked: got leak=%0d rsp_valid=%b want 0 and 1", leak, rsp_valid); end
        checks++; if ({rsp_id, rsp_p} !== e) begin errors++; $display("FAIL busy_result0: got %h want %h", {rsp_id, rsp_p}, e); end
        tb_ptr = e[8] ? 0 : 1;
        rsp_ready = 1'b1; @(posedge clk); @(negedge clk); rsp_ready = 1'b0; #1;
        model_issue(0, 1, 4'd0, 4'd0, m1, q1, w);
        checks++; if (req1_ready !== (w == 1) || req0_ready !== 1'b0) begin errors++; $display("FAIL busy_first_idle_grant: got rdy=%b%b want 01", req0_ready, req1_ready); end
        @(posedge clk); @(negedge clk); req1_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin @(posedge clk); @(negedge clk); end
        e = exp_q.pop_front();
        checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_p} !== e) begin errors++; $display("FAIL busy_result1: got v=%b %h want 1 %h", rsp_valid, {rsp_id, rsp_p}, e); end
        tb_ptr = e[8] ? 0 : 1;
        rsp_ready = 1'b1; @(posedge clk); @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] m1, q1, mm, mq; logic [7:0] p0; logic id0; logic [8:0] e; int w; bit stable;
        m1 = 4'($urandom_range(1, 15)); q1 = 4'($urandom_range(1, 15));
        model_issue(0, 1, 4'd0, 4'd0, m1, q1, w);
        @(negedge clk); req1_valid = 1'b1; req1_m = m1; req1_q = q1;
        @(posedge clk); @(negedge clk); req1_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin @(posedge clk); @(negedge clk); end
        e = exp_q.pop_front();
        p0 = rsp_p; id0 = rsp_id; mm = mul_m; mq = mul_q;
        checks++; if (rsp_valid !== 1'b1 || {id0, p0} !== e || mm !== m1 || mq !== q1) begin errors++; $display("FAIL bp_result: got v=%b %h m=%h q=%h want %h m=%h q=%h", rsp_valid, {id0, p0}, mm, mq, e, m1, q1); end
        req0_valid = 1'b1; req0_m = 4'd3; req0_q = 4'd3;
        stable = 1;
        repeat (5) begin
            @(posedge clk); @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_p !== p0 || rsp_id !== id0 || mul_m !== mm || mul_q !== mq || req0_ready || mul_load) stable = 0;
        end
        checks++; if (stable !== 1) begin errors++; $display("FAIL bp_hold_stable: got %0d want 1", stable); end
        rsp_ready = 1'b1; @(posedge clk); @(negedge clk); rsp_ready = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got v=%b rdy0=%b want 0 1", rsp_valid, req0_ready); end
        req0_valid = 1'b0;
        tb_ptr = e[8] ? 0 : 1;
    endtask

    task automatic test_reset_mid_run();
        logic r0, r1, id; logic [7:0] p; logic [8:0] e; int lat, loads, w; bit tmo, seen;
        model_issue(1, 0, 4'd3, 4'd3, 4'd0, 4'd0, w);
        transact(1, 0, 4'd3, 4'd3, 4'd0, 4'd0, 0, r0, r1, lat, loads, id, p, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo !== 0 || {id, p} !== e) begin errors++; $display("FAIL rst_pre_result: got %h tmo=%0d want %h", {id, p}, tmo, e); end
        tb_ptr = e[8] ? 0 : 1;
        @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1;
        req0_m = 4'd2; req0_q = 4'd2; req1_m = 4'd5; req1_q = 4'd6; #1;
        checks++; if (req1_ready !== 1'(tb_ptr) || req0_ready !== 1'(tb_ptr == 0)) begin errors++; $display("FAIL rst_pre_pointer: got rdy=%b%b want pointer %0d", req0_ready, req1_ready, tb_ptr); end
        @(posedge clk); @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2; reset = 1'b1; #1;
        checks++; if ({mul_load, mul_m, mul_q, rsp_valid, rsp_id, rsp_p, req0_ready, req1_ready} !== 21'd0) begin errors++; $display("FAIL rst_async_clear: got load=%b m=%h q=%h v=%b id=%b p=%h want all 0", mul_load, mul_m, mul_q, rsp_valid, rsp_id, rsp_p); end
        @(negedge clk); reset = 1'b0;
        exp_q.delete(); tb_ptr = 0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (rsp_valid || mul_load) seen = 1; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_response: got activity=%0d want 0", seen); end
        model_issue(1, 1, 4'd1, 4'd7, 4'd2, 4'd3, w);
        transact(1, 1, 4'd1, 4'd7, 4'd2, 4'd3, 0, r0, r1, lat, loads, id, p, tmo);
        e = exp_q.pop_front();
        checks++; if (tmo !== 0 || r0 !== 1'b1 || {id, p} !== e) begin errors++; $display("FAIL rst_pointer_cleared: got rdy=%b%b %h want 10 %h", r0, r1, {id, p}, e); end
        tb_ptr = e[8] ? 0 : 1;
    endtask

    task automatic test_signed_corners();
        logic [3:0] cm[3] = '{4'b1000, 4'b0111, 4'b0000};
        logic [3:0] cq[3];
        logic [7:0] cp[3] = '{8'b01000000, 8'b11001000, 8'b00000000};
        logic r0, r1, id; logic [7:0] p; int lat, loads, w; bit tmo;
        cq[0] = 4'b1000; cq[1] = 4'b1000; cq[2] = 4'($urandom_range(1, 15));
        for (int i = 0; i < 3; i++) begin
            model_issue(1, 0, cm[i], cq[i], 4'd0, 4'd0, w);
            transact(1, 0, cm[i], cq[i], 4'd0, 4'd0, 0, r0, r1, lat, loads, id, p, tmo);
            void'(exp_q.pop_front());
            checks++; if (tmo !== 0 || p !== cp[i] || id !== 1'b0) begin errors++; $display("FAIL signed_corner[%0d]: got id=%b p=%b want 0 %b", i, id, p, cp[i]); end
            tb_ptr = 1;
        end
    endtask

    task automatic test_back_to_back_random();
        logic r0, r1, id, v0, v1; logic [7:0] p; logic [3:0] m0, q0, m1, q1; logic [8:0] e;
        int lat, loads, w, v; bit tmo;
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(1, 3); v0 = v[0]; v1 = v[1];
            m0 = 4'($urandom_range(0, 15)); q0 = 4'($urandom_range(0, 15));
            m1 = 4'($urandom_range(0, 15)); q1 = 4'($urandom_range(0, 15));
            model_issue(v0, v1, m0, q0, m1, q1, w);
            transact(v0, v1, m0, q0, m1, q1, $urandom_range(0, 3), r0, r1, lat, loads, id, p, tmo);
            e = exp_q.pop_front();
            checks++; if (tmo !== 0 || r0 !== (w == 0) || r1 !== (w == 1) || lat !== LAT + 1 || loads !== 1) begin errors++; $display("FAIL random_timing[%0d]: got rdy=%b%b lat=%0d loads=%0d tmo=%0d want winner %0d lat %0d", i, r0, r1, lat, loads, tmo, w, LAT + 1); end
            checks++; if ({id, p} !== e) begin errors++; $display("FAIL random_result[%0d]: got %h want %h", i, {id, p}, e); end
            tb_ptr = e[8] ? 0 : 1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_busy_blocking();
        test_backpressure();
        test_reset_mid_run();
        test_signed_corners();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
